// File: rtl/fpu_pkg.sv
// ============================================================================
// Module   : fpu_pkg
// Desc     : Shared types and constants for the sequential FP add/sub unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
  function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_addsub_seq_if.sv
// ============================================================================
// Module   : fpu_addsub_seq_if
// Desc     : Request/response handshake bundle for fpu_addsub_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpu_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int c_w = 1 + EXP_W + MAN_W;

  logic           in_valid;
  logic           in_ready;
  logic [c_w-1:0] a;
  logic [c_w-1:0] b;
  logic           op;
  logic           out_valid;
  logic           out_ready;
  logic [c_w-1:0] result;
  logic [3:0]     flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

`default_nettype wire

// File: rtl/fpu_lzc.sv
// ============================================================================
// Module   : fpu_lzc
// Desc     : Parametrised leading-zero counter over the normaliser significand.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire logic [WIDTH-1:0] value,
  output logic      [CNT_W-1:0] count
);

  // Highest set bit wins because it is visited last.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_addsub_seq.sv
// ============================================================================
// Module   : fpu_addsub_seq
// Desc     : Multi-cycle IEEE-754 add/subtract, fixed 4-cycle latency.
//            FPU_ROUND_EN selects round-to-nearest-even; otherwise truncate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_addsub_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input wire logic         clk,
  input wire logic         reset,
  fpu_addsub_seq_if.slave  bus
);

  localparam int c_w     = 1 + EXP_W + MAN_W;
  localparam int c_ext_w = MAN_W + 4;            // hidden, fraction, G, R, S
  localparam int c_sum_w = MAN_W + 5;            // plus carry
  localparam int c_sat   = MAN_W + 3;
  localparam int c_cnt_w = $clog2(c_ext_w + 1);
  localparam int c_e_w   = EXP_W + c_cnt_w + 1;  // signed working exponent
  localparam logic [EXP_W-1:0]        c_exp_ones = '1;
  localparam logic signed [c_e_w-1:0] c_exp_max  = c_e_w'((1 << EXP_W) - 1);
  localparam logic [c_w-1:0]          c_qnan     = c_w'(canonical_nan(EXP_W, MAN_W));

  state_t r_state, w_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.in_valid) w_next = ST_ALIGN;
      ST_ALIGN: w_next = ST_ADD;
      ST_ADD:   w_next = ST_NORM;
      ST_NORM:  w_next = ST_ROUND;
      ST_ROUND: w_next = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // ---------------- capture-time decode and special values ----------------
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic             w_b_sign;
  logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;
  logic             w_spec;
  logic [c_w-1:0]   w_spec_res;
  logic [3:0]       w_spec_flags;

  assign w_a_exp  = bus.a[c_w-2 -: EXP_W];
  assign w_b_exp  = bus.b[c_w-2 -: EXP_W];
  assign w_a_frac = bus.a[MAN_W-1:0];
  assign w_b_frac = bus.b[MAN_W-1:0];
  assign w_b_sign = bus.b[c_w-1] ^ (bus.op == OP_SUB);
  assign w_a_nan  = (w_a_exp == c_exp_ones) && (w_a_frac != '0);
  assign w_b_nan  = (w_b_exp == c_exp_ones) && (w_b_frac != '0);
  assign w_a_snan = w_a_nan && !w_a_frac[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_b_frac[MAN_W-1];
  assign w_a_inf  = (w_a_exp == c_exp_ones) && (w_a_frac == '0);
  assign w_b_inf  = (w_b_exp == c_exp_ones) && (w_b_frac == '0);

  always_comb begin
    w_spec       = 1'b0;
    w_spec_res   = '0;
    w_spec_flags = '0;
    if (w_a_nan || w_b_nan) begin
      w_spec                     = 1'b1;
      w_spec_res                 = c_qnan;
      w_spec_flags[FLAG_INVALID] = w_a_snan || w_b_snan;
    end else if (w_a_inf && w_b_inf && (bus.a[c_w-1] != w_b_sign)) begin
      w_spec                     = 1'b1;
      w_spec_res                 = c_qnan;
      w_spec_flags[FLAG_INVALID] = 1'b1;
    end else if (w_a_inf) begin
      w_spec     = 1'b1;
      w_spec_res = bus.a;
    end else if (w_b_inf) begin
      w_spec     = 1'b1;
      w_spec_res = {w_b_sign, bus.b[c_w-2:0]};
    end
  end

  // ---------------- datapath registers ----------------
  logic               r_sa, r_sb, r_sign, r_zsign, r_sub, r_spec, r_zero, r_uflow;
  logic [EXP_W-1:0]   r_ea, r_eb, r_exp;
  logic [MAN_W-1:0]   r_fa, r_fb;
  logic [c_w-1:0]     r_spec_res, r_result;
  logic [3:0]         r_spec_flags, r_flags;
  logic [c_ext_w-1:0] r_x, r_y, r_nsig;
  logic [c_sum_w-1:0] r_sum;
  logic signed [c_e_w-1:0] r_nexp;

  // Align: larger magnitude goes to x, smaller is shifted with sticky collection.
  logic               w_swap;
  logic [EXP_W-1:0]   w_big_e, w_sml_e;
  logic [c_ext_w-1:0] w_big_sig, w_sml_sig, w_shifted, w_aligned;
  logic [31:0]        w_diff, w_sh;
  logic               w_lost;

  assign w_swap    = {r_eb, r_fb} > {r_ea, r_fa};
  assign w_big_e   = w_swap ? r_eb : r_ea;
  assign w_sml_e   = w_swap ? r_ea : r_eb;
  assign w_big_sig = {w_big_e != '0, (w_swap ? r_fb : r_fa), 3'b000};
  assign w_sml_sig = {w_sml_e != '0, (w_swap ? r_fa : r_fb), 3'b000};
  assign w_diff    = 32'(w_big_e) - 32'(w_sml_e);
  assign w_sh      = (w_diff > 32'(c_sat)) ? 32'(c_sat) : w_diff;
  assign w_shifted = w_sml_sig >> w_sh;
  assign w_lost    = |(w_sml_sig & ~({c_ext_w{1'b1}} << w_sh));
  assign w_aligned = {w_shifted[c_ext_w-1:1], w_shifted[0] | w_lost};

  // Normalise.
  logic [c_cnt_w-1:0]      w_lz;
  logic [c_ext_w-1:0]      w_nsig;
  logic signed [c_e_w-1:0] w_nexp;

  fpu_lzc #(.WIDTH(c_ext_w), .CNT_W(c_cnt_w)) u_lzc (
    .value (r_sum[c_ext_w-1:0]),
    .count (w_lz)
  );

  always_comb begin
    if (r_sum[c_sum_w-1]) begin
      w_nsig = {r_sum[c_sum_w-1:2], r_sum[1] | r_sum[0]};
      w_nexp = c_e_w'(r_exp) + c_e_w'(1);
    end else begin
      w_nsig = r_sum[c_ext_w-1:0] << w_lz;
      w_nexp = c_e_w'(r_exp) - c_e_w'(w_lz);
    end
  end

  // Round and pack.
  logic                    w_up, w_inexact, w_ovf;
  logic [MAN_W+1:0]        w_mant;
  logic [MAN_W-1:0]        w_frac;
  logic signed [c_e_w-1:0] w_rexp;
  logic [c_w-1:0]          w_res;
  logic [3:0]              w_flags;

`ifdef FPU_ROUND_EN
  assign w_up = r_nsig[2] & (r_nsig[1] | r_nsig[0] | r_nsig[3]);
`else
  assign w_up = 1'b0;
`endif
  assign w_inexact = |r_nsig[2:0];
  assign w_mant    = {1'b0, r_nsig[c_ext_w-1:3]} + (MAN_W+2)'(w_up);
  assign w_frac    = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];
  assign w_rexp    = r_nexp + c_e_w'(w_mant[MAN_W+1]);
  assign w_ovf     = !w_rexp[c_e_w-1] && (w_rexp >= c_exp_max);

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    if (r_spec) begin
      w_res   = r_spec_res;
      w_flags = r_spec_flags;
    end else if (r_zero) begin
      w_res = {r_zsign, {(c_w-1){1'b0}}};
    end else if (r_uflow) begin
      w_res                     = {r_sign, {(c_w-1){1'b0}}};
      w_flags[FLAG_UNDERFLOW]   = 1'b1;
      w_flags[FLAG_INEXACT]     = 1'b1;
    end else if (w_ovf) begin
`ifdef FPU_ROUND_EN
      w_res = {r_sign, c_exp_ones, {MAN_W{1'b0}}};
`else
      w_res = {r_sign, c_exp_ones - EXP_W'(1), {MAN_W{1'b1}}};
`endif
      w_flags[FLAG_OVERFLOW] = 1'b1;
      w_flags[FLAG_INEXACT]  = 1'b1;
    end else begin
      w_res                 = {r_sign, w_rexp[EXP_W-1:0], w_frac};
      w_flags[FLAG_INEXACT] = w_inexact;
    end
  end

  always_ff @(posedge clk) begin
    case (r_state)
      ST_IDLE: if (bus.in_valid) begin
        r_sa         <= bus.a[c_w-1];
        r_sb         <= w_b_sign;
        r_ea         <= w_a_exp;
        r_eb         <= w_b_exp;
        r_fa         <= (w_a_exp == '0) ? '0 : w_a_frac;
        r_fb         <= (w_b_exp == '0) ? '0 : w_b_frac;
        r_spec       <= w_spec;
        r_spec_res   <= w_spec_res;
        r_spec_flags <= w_spec_flags;
      end
      ST_ALIGN: begin
        r_x     <= w_big_sig;
        r_y     <= w_aligned;
        r_exp   <= w_big_e;
        r_sign  <= w_swap ? r_sb : r_sa;
        r_zsign <= r_sa & r_sb;
        r_sub   <= r_sa ^ r_sb;
      end
      ST_ADD: begin
        r_sum <= r_sub ? ({1'b0, r_x} - {1'b0, r_y}) : ({1'b0, r_x} + {1'b0, r_y});
      end
      ST_NORM: begin
        r_nsig  <= w_nsig;
        r_nexp  <= w_nexp;
        r_zero  <= (r_sum == '0);
        r_uflow <= w_nexp[c_e_w-1] || (w_nexp == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (r_state == ST_ROUND) begin
      r_result <= w_res;
      r_flags  <= w_flags;
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_fpu_addsub_seq.sv
// ============================================================================
// Module   : tb_fpu_addsub_seq
// Desc     : Directed self-checking bench for fpu_addsub_seq (binary32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_addsub_seq;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  fpu_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fpu_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iop);
    bus.a = ia; bus.b = ib; bus.op = iop; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.op = ~iop;
  endtask

  task automatic collect(input string tag, input logic [31:0] er, input logic [3:0] ef);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_res"}, 64'(bus.result), 64'(er));
    check({tag, "_flg"}, 64'(bus.flags), 64'(ef));
  endtask

  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic iop, input logic [31:0] er, input logic [3:0] ef);
    issue(ia, ib, iop);
    collect(tag, er, ef);
    step();
  endtask

  initial begin
    logic stable;
    int   seen;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.op = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result",    64'(bus.result),    64'd0);
    check("rst_flags",     64'(bus.flags),     64'd0);

    issue(32'h4048F5C3, 32'h00000000, 1'b0);
    check("busy_after_accept", 64'(bus.in_ready), 64'd0);
    collect("add_zero", 32'h4048F5C3, 4'b0000);
    step();
    check("idle_after_hs", 64'(bus.in_ready), 64'd1);

    run_op("dbl",      32'h4048F5C3, 32'h4048F5C3, 1'b0, 32'h40C8F5C3, 4'b0000);
    run_op("add_diff", 32'h40C8F5C3, 32'h4048F5C3, 1'b0, 32'h4116B852, 4'b0001);
    run_op("a_sub_a",  32'h4048F5C3, 32'h4048F5C3, 1'b1, 32'h00000000, 4'b0000);
    run_op("sub_norm", 32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'b0000);
    run_op("sub_swap", 32'h3F400000, 32'h3F800000, 1'b1, 32'hBE800000, 4'b0000);
`ifdef FPU_ROUND_EN
    run_op("round",    32'h3F800001, 32'h33C00000, 1'b0, 32'h3F800002, 4'b0001);
    run_op("ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
`else
    run_op("round",    32'h3F800001, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001);
    run_op("ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 4'b0101);
`endif
    run_op("inf_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    run_op("snan",     32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_op("qnan",     32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    run_op("ninf",     32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    run_op("nz_nz",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    run_op("pz_nz",    32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
    run_op("subn",     32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
    run_op("uflow",    32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);

    // Consumer stalls for ten cycles in DONE.
    bus.out_ready = 1'b0;
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    collect("stall", 32'h40000000, 4'b0000);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.result !== 32'h40000000 || bus.flags !== 4'b0000 ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    check("stall_hold", 64'(stable), 64'd1);
    bus.a = 32'h40000000; bus.b = 32'h3F800000; bus.op = 1'b1; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("stall_release_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check("b2b_accepted", 64'(bus.in_ready), 64'd0);
    collect("b2b", 32'h3F800000, 4'b0000);
    step();

    // Reset while the operation sits in NORM.
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_result",    64'(bus.result),    64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("midrst_no_stale", 64'(seen), 64'd0);

    run_op("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
